// File: rtl/fetch_pkg.sv
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared fetch-stage codes: PC select, NOP encoding, FSM states.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int PC_SEL_WIDTH = 2;

    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_SEQ  = 2'd0;
    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_BR   = 2'd1;
    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_JAL  = 2'd2;
    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_JALR = 2'd3;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_SQUASH = 2'd1,
        ST_HOLD   = 2'd2
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/pc_target_sel.sv
// ============================================================================
//  Module      : pc_target_sel
//  Description : Redirect decode plus word-aligned redirect target mux.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module pc_target_sel
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [PC_SEL_WIDTH-1:0] pc_sel,
    input  logic                    br_true,
    input  logic [XLEN-1:0]         br_decode,
    input  logic [XLEN-1:0]         jal_decode,
    input  logic [XLEN-1:0]         jalr_decode,
    output logic                    redirect,
    output logic [XLEN-1:0]         target
);

    logic [XLEN-1:0] w_raw_target;

    always_comb begin
        redirect     = 1'b0;
        w_raw_target = br_decode;
        case (pc_sel)
            PC_SEL_BR: begin
                redirect     = br_true;
                w_raw_target = br_decode;
            end
            PC_SEL_JAL: begin
                redirect     = 1'b1;
                w_raw_target = jal_decode;
            end
            PC_SEL_JALR: begin
                redirect     = 1'b1;
                w_raw_target = jalr_decode;
            end
            default: begin
                redirect     = 1'b0;
                w_raw_target = br_decode;
            end
        endcase
    end

    assign target = {w_raw_target[XLEN-1:2], 2'b00};

endmodule

`default_nettype wire

// File: rtl/fetch.sv
// ============================================================================
//  Module      : fetch
//  Description : RV32I instruction fetch stage: fetch PC, imem req/ack FSM,
//                IF/ID register, redirect squashing and NOP bubble injection.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    imem_req,
    output logic [XLEN-1:0]         imem_addr,
    input  logic                    imem_ack,
    input  logic [XLEN-1:0]         imem_rdata,
    input  logic                    stall,
    input  logic [PC_SEL_WIDTH-1:0] pc_sel,
    input  logic                    br_true,
    input  logic [XLEN-1:0]         br_decode,
    input  logic [XLEN-1:0]         jal_decode,
    input  logic [XLEN-1:0]         jalr_decode,
    output logic [XLEN-1:0]         pc_decode,
    output logic [XLEN-1:0]         instr_decode
);

    localparam logic [XLEN-1:0] c_nop = XLEN'(NOP_INSTR);

    fetch_state_e    r_state;
    logic            r_live;
    logic [XLEN-1:0] r_pc_fetch;
    logic [XLEN-1:0] r_pending;
    logic [XLEN-1:0] r_hold_instr;
    logic [XLEN-1:0] r_pc_decode;
    logic [XLEN-1:0] r_instr_decode;

    logic            w_redirect;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_next;

    pc_target_sel #(
        .XLEN (XLEN)
    ) u_pc_target_sel (
        .pc_sel      (pc_sel),
        .br_true     (br_true),
        .br_decode   (br_decode),
        .jal_decode  (jal_decode),
        .jalr_decode (jalr_decode),
        .redirect    (w_redirect),
        .target      (w_target)
    );

    assign w_pc_next = r_pc_fetch + XLEN'(4);

    // r_live keeps the request low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_REQ;
            r_live         <= 1'b0;
            r_pc_fetch     <= RESET_PC;
            r_pending      <= '0;
            r_hold_instr   <= '0;
            r_pc_decode    <= '0;
            r_instr_decode <= c_nop;
        end else if (!r_live) begin
            r_live <= 1'b1;
        end else begin
            if (w_redirect) begin
                r_instr_decode <= c_nop;
            end
            case (r_state)
                ST_REQ: begin
                    if (imem_ack) begin
                        if (w_redirect) begin
                            r_pc_fetch <= w_target;
                        end else if (!stall) begin
                            r_pc_decode    <= r_pc_fetch;
                            r_instr_decode <= imem_rdata;
                            r_pc_fetch     <= w_pc_next;
                        end else begin
                            r_hold_instr <= imem_rdata;
                            r_state      <= ST_HOLD;
                        end
                    end else if (w_redirect) begin
                        r_pending <= w_target;
                        r_state   <= ST_SQUASH;
                    end else if (!stall) begin
                        r_instr_decode <= c_nop;
                    end
                end
                ST_SQUASH: begin
                    if (!stall) begin
                        r_instr_decode <= c_nop;
                    end
                    // A redirect in the ack cycle is the newest target.
                    if (imem_ack) begin
                        r_pc_fetch <= w_redirect ? w_target : r_pending;
                        r_state    <= ST_REQ;
                    end else if (w_redirect) begin
                        r_pending <= w_target;
                    end
                end
                ST_HOLD: begin
                    if (w_redirect) begin
                        r_pc_fetch <= w_target;
                        r_state    <= ST_REQ;
                    end else if (!stall) begin
                        r_pc_decode    <= r_pc_fetch;
                        r_instr_decode <= r_hold_instr;
                        r_pc_fetch     <= w_pc_next;
                        r_state        <= ST_REQ;
                    end
                end
                default: begin
                    r_state <= ST_REQ;
                end
            endcase
        end
    end

    assign imem_req     = r_live && (r_state != ST_HOLD);
    assign imem_addr    = r_pc_fetch;
    assign pc_decode    = r_pc_decode;
    assign instr_decode = r_instr_decode;

endmodule

`default_nettype wire
